// File: rtl/tpx3_tx_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : tpx3_tx_core_if
//  Purpose  : First-word-fall-through FIFO read port between a word source
//             and the tpx3_tx_core serial transmitter.
//  Signals  : FIFO_EMPTY  source FIFO empty
//             FIFO_DATA   head word, valid while FIFO_EMPTY = 0
//             FIFO_READ   one-cycle pop strobe from the transmitter
//  Modports : master - FIFO / word source side
//             slave  - transmitter side
//  Revision : 1.0  initial release
// ============================================================================
interface tpx3_tx_core_if;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ;

    modport master (
        output FIFO_EMPTY,
        output FIFO_DATA,
        input  FIFO_READ
    );

    modport slave (
        input  FIFO_EMPTY,
        input  FIFO_DATA,
        output FIFO_READ
    );
endinterface
`default_nettype wire

// File: rtl/tpx3_tx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tpx3_tx_core
//  Purpose  : 8b10b serial transmitter. Pops 32-bit words from an FWFT FIFO,
//             sends each as four data symbols (byte 3 first) and fills idle
//             time with K28.5 commas. One line bit per BUS_CLK.
//  Ports    : BUS_CLK   sole clock, rising edge
//             BUS_RST   asynchronous active-high reset
//             ENABLE    transmitter enable (level)
//             fifo      FIFO read port (slave modport)
//             TX_DATA   serial line, bit 'a' of each symbol first
//             TX_READY  high once the sync comma train is complete
//             TX_BUSY   high while a data word is on the line
//             WORD_CNT  words popped, wraps modulo 2^CNT_WIDTH
//  Revision : 1.0  initial release
// ============================================================================
module tpx3_tx_core #(
    parameter int SYNC_COMMAS = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  wire                  BUS_CLK,
    input  wire                  BUS_RST,
    input  wire                  ENABLE,
    tpx3_tx_core_if.slave        fifo,
    output logic                 TX_DATA,
    output logic                 TX_READY,
    output logic                 TX_BUSY,
    output logic [CNT_WIDTH-1:0] WORD_CNT
);

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_SYNC     = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    localparam logic [9:0] C_K285_NEG = 10'b0011111010;
    localparam logic [9:0] C_K285_POS = 10'b1100000101;
    localparam logic [7:0] C_SYNC     = 8'(SYNC_COMMAS);

    // Symbol code layout is {a,b,c,d,e,i,f,g,h,j}; rd = 1 means RD+.
    // Returns {rd_after, code}.
    function automatic logic [10:0] f_enc(input logic [7:0] d, input logic rd);
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd6;
        logic       rd4;
        logic       a7;
        logic [4:0] x;
        logic [2:0] y;
        x = d[4:0];
        y = d[7:5];
        // 5b/6b, RD- column
        case (x)
            5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
            5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
            5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
            5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
            5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
            5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
            5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
            5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
            5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
            5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
            5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
            5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
            5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
            5'd30: c6 = 6'b011110;  default: c6 = 6'b101011;
        endcase
        // RD+ form is the complement for unbalanced codes and for D.07
        if (rd && (($countones(c6) != 3) || (x == 5'd7))) begin
            c6 = ~c6;
        end
        rd6 = ($countones(c6) != 3) ? ~rd : rd;

        // A7 replaces P7 where P7 would create a run of five equal bits
        a7 = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
             ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        case (y)
            3'd0:    c4 = 4'b1011;
            3'd1:    c4 = 4'b1001;
            3'd2:    c4 = 4'b0101;
            3'd3:    c4 = 4'b1100;
            3'd4:    c4 = 4'b1101;
            3'd5:    c4 = 4'b1010;
            3'd6:    c4 = 4'b0110;
            default: c4 = a7 ? 4'b0111 : 4'b1110;
        endcase
        if (rd6 && (($countones(c4) != 2) || (y == 3'd3))) begin
            c4 = ~c4;
        end
        rd4 = ($countones(c4) != 2) ? ~rd6 : rd6;
        return {rd4, c6, c4};
    endfunction

    state_t                 r_state;
    logic [9:0]             r_shreg;
    logic [3:0]             r_bit_cnt;
    logic                   r_rd;
    logic [7:0]             r_comma_cnt;
    logic [1:0]             r_bytes_left;
    logic [23:0]            r_word;       // byte 3 goes out at the pop, so only 2..0 are kept
    logic                   r_busy;
    logic [CNT_WIDTH-1:0]   r_word_cnt;

    state_t                 w_state_nxt;
    logic [9:0]             w_shreg_nxt;
    logic [3:0]             w_cnt_nxt;
    logic                   w_rd_nxt;
    logic [7:0]             w_comma_nxt;
    logic [1:0]             w_left_nxt;
    logic [23:0]            w_word_nxt;
    logic                   w_busy_nxt;
    logic [CNT_WIDTH-1:0]   w_wcnt_nxt;
    logic                   w_fifo_read;
    logic                   w_boundary;
    logic                   w_run_rules;
    logic                   w_go_idle;
    logic                   w_load_k;
    logic                   w_load_d;
    logic [7:0]             w_byte;
    logic [10:0]            w_enc;

    assign w_boundary = (r_bit_cnt == 4'd9);

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = {r_shreg[8:0], 1'b0};
        w_cnt_nxt   = r_bit_cnt + 4'd1;
        w_rd_nxt    = r_rd;
        w_comma_nxt = r_comma_cnt;
        w_left_nxt  = r_bytes_left;
        w_word_nxt  = r_word;
        w_busy_nxt  = r_busy;
        w_wcnt_nxt  = r_word_cnt;
        w_fifo_read = 1'b0;
        w_run_rules = 1'b0;
        w_go_idle   = 1'b0;
        w_load_k    = 1'b0;
        w_load_d    = 1'b0;
        w_byte      = 8'h00;

        case (r_state)
            S_DISABLED: begin
                if (ENABLE) begin
                    w_load_k    = 1'b1;
                    w_comma_nxt = 8'd1;
                    w_state_nxt = S_SYNC;
                end else begin
                    w_go_idle = 1'b1;
                end
            end
            S_SYNC: begin
                if (w_boundary) begin
                    if (!ENABLE) begin
                        w_go_idle = 1'b1;
                    end else if (r_comma_cnt >= C_SYNC) begin
                        // The last sync comma finishes here: this boundary already belongs to RUN
                        w_state_nxt = S_RUN;
                        w_run_rules = 1'b1;
                    end else begin
                        w_load_k    = 1'b1;
                        w_comma_nxt = (r_comma_cnt == 8'hFF) ? r_comma_cnt : r_comma_cnt + 8'd1;
                    end
                end
            end
            S_RUN: begin
                if (w_boundary) begin
                    w_run_rules = 1'b1;
                end
            end
            default: begin
                w_go_idle = 1'b1;
            end
        endcase

        if (w_run_rules) begin
            if (r_bytes_left != 2'd0) begin
                // Remainder of the latched word goes out even if ENABLE has dropped
                w_load_d   = 1'b1;
                w_left_nxt = r_bytes_left - 2'd1;
                case (r_bytes_left)
                    2'd3:    w_byte = r_word[23:16];
                    2'd2:    w_byte = r_word[15:8];
                    default: w_byte = r_word[7:0];
                endcase
            end else if (ENABLE && !fifo.FIFO_EMPTY) begin
                w_fifo_read = 1'b1;
                w_word_nxt  = fifo.FIFO_DATA[23:0];
                w_byte      = fifo.FIFO_DATA[31:24];
                w_load_d    = 1'b1;
                w_left_nxt  = 2'd3;
                w_busy_nxt  = 1'b1;
                w_wcnt_nxt  = r_word_cnt + CNT_WIDTH'(1);
            end else if (ENABLE) begin
                w_load_k   = 1'b1;
                w_busy_nxt = 1'b0;
            end else begin
                w_go_idle = 1'b1;
            end
        end

        w_enc = f_enc(w_byte, r_rd);

        if (w_go_idle) begin
            w_state_nxt = S_DISABLED;
            w_shreg_nxt = 10'd0;
            w_cnt_nxt   = 4'd0;
            w_rd_nxt    = 1'b0;
            w_comma_nxt = 8'd0;
            w_busy_nxt  = 1'b0;
        end else if (w_load_k) begin
            w_shreg_nxt = r_rd ? C_K285_POS : C_K285_NEG;
            w_rd_nxt    = ~r_rd;
            w_cnt_nxt   = 4'd0;
        end else if (w_load_d) begin
            w_shreg_nxt = w_enc[9:0];
            w_rd_nxt    = w_enc[10];
            w_cnt_nxt   = 4'd0;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state      <= S_DISABLED;
            r_shreg      <= 10'd0;
            r_bit_cnt    <= 4'd0;
            r_rd         <= 1'b0;
            r_comma_cnt  <= 8'd0;
            r_bytes_left <= 2'd0;
            r_word       <= 24'd0;
            r_busy       <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_rd         <= w_rd_nxt;
            r_comma_cnt  <= w_comma_nxt;
            r_bytes_left <= w_left_nxt;
            r_word       <= w_word_nxt;
            r_busy       <= w_busy_nxt;
            r_word_cnt   <= w_wcnt_nxt;
        end
    end

    assign fifo.FIFO_READ = w_fifo_read;
    assign TX_DATA        = r_shreg[9];
    assign TX_READY       = (r_state == S_RUN);
    assign TX_BUSY        = r_busy;
    assign WORD_CNT       = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tpx3_tx_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tpx3_tx_core
//  Purpose  : Self-checking bench for tpx3_tx_core: FWFT FIFO model, serial
//             line monitor with comma alignment and a byte scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tpx3_tx_core;

    localparam logic [9:0] K_NEG = 10'b0011111010;
    localparam logic [9:0] K_POS = 10'b1100000101;

    logic       BUS_CLK = 1'b0;
    logic       BUS_RST = 1'b1;
    logic       ENABLE  = 1'b0;
    logic       TX_DATA;
    logic       TX_READY;
    logic       TX_BUSY;
    logic [3:0] WORD_CNT;

    int checks = 0;
    int errors = 0;

    tpx3_tx_core_if fif ();

    tpx3_tx_core #(
        .SYNC_COMMAS (16),
        .CNT_WIDTH   (4)
    ) dut (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .ENABLE   (ENABLE),
        .fifo     (fif),
        .TX_DATA  (TX_DATA),
        .TX_READY (TX_READY),
        .TX_BUSY  (TX_BUSY),
        .WORD_CNT (WORD_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int          pop_times[$];
    int          cyc = 0;
    int          pop_cnt = 0;
    int          lock_commas = 0;
    int          sync_seen = 0;
    bit          got_data = 1'b0;
    logic [7:0]  tbl [4] = '{8'h00, 8'hB5, 8'hFF, 8'hF1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-derived 8b10b codes for the bytes used here; returns {rd_after, symbol}
    function automatic logic [10:0] model(input logic [7:0] b, input bit rd);
        logic [10:0] r;
        case (b)
            8'h00:   r = rd ? {1'b1, 10'b0110001011} : {1'b0, 10'b1001110100};
            8'hB5:   r = {rd, 10'b1010101010};
            8'hFF:   r = rd ? {1'b1, 10'b0101001110} : {1'b0, 10'b1010110001};
            8'hF1:   r = rd ? {1'b0, 10'b1000110001} : {1'b1, 10'b1000110111};
            default: r = {rd, 10'b0};
        endcase
        return r;
    endfunction

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n;
        n = 0;
        while (pop_cnt < target && n < budget) begin
            @(negedge BUS_CLK);
            #1;
            n++;
        end
        chk("pop_wait", pop_cnt >= target, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge BUS_CLK);
            #1;
            n++;
        end
        chk("drain_wait", exp_q.size(), 0);
    endtask

    // FWFT FIFO: pop is applied just after the edge on which FIFO_READ was high
    initial begin : fifo_model
        bit fr;
        fif.FIFO_EMPTY = 1'b1;
        fif.FIFO_DATA  = 32'h0;
        forever begin
            @(negedge BUS_CLK);
            fr = fif.FIFO_READ;
            if (fr) begin
                chk("pop_only_when_nonempty", fif.FIFO_EMPTY, 0);
                pop_cnt++;
                pop_times.push_back(cyc);
            end
            @(posedge BUS_CLK);
            cyc++;
            #1;
            if (fr && fifo_q.size() > 0) void'(fifo_q.pop_front());
            fif.FIFO_EMPTY = (fifo_q.size() == 0);
            fif.FIFO_DATA  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        end
    end

    // Line monitor: aligns on the first K28.5 after idle, then checks every symbol
    initial begin : monitor
        logic [9:0]  win;
        logic [10:0] m;
        logic [7:0]  b;
        bit          locked;
        bit          mrd;
        int          nb;
        int          bpos;
        win = 10'd0; locked = 1'b0; mrd = 1'b0; nb = 0; bpos = 0;
        forever begin
            @(negedge BUS_CLK);
            if (BUS_RST) begin
                win = 10'd0; locked = 1'b0; mrd = 1'b0; nb = 0; bpos = 0;
                exp_q.delete();
            end else begin
                win = {win[8:0], TX_DATA};
                if (!locked) begin
                    if (win == K_NEG) begin
                        locked = 1'b1; nb = 0; mrd = 1'b1; bpos = 0;
                        lock_commas = 1; got_data = 1'b0;
                    end
                end else begin
                    nb++;
                    if (nb == 10) begin
                        nb = 0;
                        if (win == 10'd0) begin
                            chk("word_cut_by_idle", bpos, 0);
                            locked = 1'b0; mrd = 1'b0; bpos = 0;
                        end else if (win == K_NEG || win == K_POS) begin
                            chk("comma_rd", win, mrd ? K_POS : K_NEG);
                            chk("comma_inside_word", bpos, 0);
                            mrd = ~mrd;
                            if (!got_data) lock_commas++;
                        end else begin
                            chk("data_expected", exp_q.size() != 0, 1);
                            if (exp_q.size() != 0) begin
                                b = exp_q.pop_front();
                                m = model(b, mrd);
                                chk($sformatf("symbol_byte_%02h", b), win, m[9:0]);
                                mrd  = m[10];
                                bpos = (bpos + 1) % 4;
                                if (!got_data) begin
                                    got_data  = 1'b1;
                                    sync_seen = lock_commas;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        int base;
        int pc;
        logic idle_or;
        logic [31:0] w;

        BUS_RST = 1'b1;
        ENABLE  = 1'b0;
        repeat (3) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        @(negedge BUS_CLK);
        chk("reset_tx_data",   TX_DATA, 0);
        chk("reset_fifo_read", fif.FIFO_READ, 0);
        chk("reset_tx_ready",  TX_READY, 0);
        chk("reset_tx_busy",   TX_BUSY, 0);
        chk("reset_word_cnt",  WORD_CNT, 0);

        // Enable with empty FIFO: 16 sync commas, READY at the 160th edge
        ENABLE = 1'b1;
        @(posedge BUS_CLK);
        n = 0;
        while (n < 400) begin
            @(posedge BUS_CLK);
            #1;
            n++;
            if (TX_READY) break;
        end
        chk("ready_latency", n, 160);
        repeat (45) @(negedge BUS_CLK);
        chk("no_pop_when_empty", pop_cnt, 0);
        chk("idle_not_busy", TX_BUSY, 0);

        // Back-to-back words in RUN
        @(negedge BUS_CLK);
        base = pop_times.size();
        push_word(32'hB5B5B5B5);
        push_word(32'h00000000);
        wait_pops(base + 1, 200);
        @(posedge BUS_CLK);
        #1;
        chk("busy_after_pop", TX_BUSY, 1);
        wait_pops(base + 2, 200);
        wait_drain(200);
        repeat (15) @(negedge BUS_CLK);
        chk("busy_cleared", TX_BUSY, 0);
        chk("pop_spacing_b2b", pop_times[base + 1] - pop_times[base], 40);
        chk("word_cnt_two", WORD_CNT, 2);

        // Words that swing running disparity (A7/P7 and complement paths)
        base = pop_times.size();
        push_word(32'hF1F1F1F1);
        push_word(32'hFF00F1B5);
        wait_pops(base + 2, 300);
        wait_drain(200);
        chk("pop_spacing_rd", pop_times[base + 1] - pop_times[base], 40);
        chk("word_cnt_four", WORD_CNT, 4);

        // ENABLE dropped mid-word with another word waiting
        @(negedge BUS_CLK);
        pc = pop_cnt;
        push_word(32'hF1B500FF);
        push_word(32'h00000000);
        wait_pops(pc + 1, 200);
        repeat (15) @(negedge BUS_CLK);
        ENABLE = 1'b0;
        n = 0;
        while (TX_READY && n < 200) begin
            @(negedge BUS_CLK);
            n++;
        end
        chk("ready_falls", TX_READY, 0);
        chk("word_finished_before_stop", exp_q.size(), 4);
        idle_or = 1'b0;
        repeat (30) begin
            @(negedge BUS_CLK);
            idle_or = idle_or | TX_DATA;
        end
        chk("disabled_line_low", idle_or, 0);
        chk("no_pop_after_disable", pop_cnt, pc + 1);
        chk("fifo_word_left", fifo_q.size(), 1);
        chk("word_cnt_five", WORD_CNT, 5);

        // Re-enable with preloaded FIFO: pop exactly after 16 commas
        ENABLE = 1'b1;
        @(posedge BUS_CLK);
        n = 0;
        while (n < 400) begin
            @(negedge BUS_CLK);
            n++;
            if (fif.FIFO_READ) break;
        end
        chk("first_pop_latency", n, 160);
        wait_drain(200);
        chk("sync_comma_count", sync_seen, 16);
        chk("word_cnt_six", WORD_CNT, 6);

        // Eleven more words back-to-back: 4-bit counter wraps to 1
        @(negedge BUS_CLK);
        base = pop_times.size();
        pc   = pop_cnt;
        for (int i = 0; i < 11; i++) begin
            w = {tbl[$urandom_range(3)], tbl[$urandom_range(3)],
                 tbl[$urandom_range(3)], tbl[$urandom_range(3)]};
            push_word(w);
        end
        wait_pops(pc + 11, 1000);
        wait_drain(200);
        for (int i = 1; i < 11; i++) begin
            chk($sformatf("pop_spacing_burst_%0d", i),
                pop_times[base + i] - pop_times[base + i - 1], 40);
        end
        chk("word_cnt_wrap", WORD_CNT, 1);

        // Asynchronous reset in the middle of a word
        @(negedge BUS_CLK);
        pc = pop_cnt;
        push_word(32'hB5B5B5B5);
        wait_pops(pc + 1, 200);
        repeat (13) @(negedge BUS_CLK);
        #2;
        BUS_RST = 1'b1;
        #1;
        chk("midword_rst_tx_data",   TX_DATA, 0);
        chk("midword_rst_fifo_read", fif.FIFO_READ, 0);
        chk("midword_rst_tx_ready",  TX_READY, 0);
        chk("midword_rst_tx_busy",   TX_BUSY, 0);
        chk("midword_rst_word_cnt",  WORD_CNT, 0);
        repeat (3) @(negedge BUS_CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
